truxton2_prg_cache: RTL



---
 rtl/truxton2_pkg.sv | 22 ++
 rtl/truxton2_prg_cache_if.sv | 18 +
 rtl/truxton2_dpram.sv | 30 +++
 rtl/truxton2_prg_cache.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/truxton2_pkg.sv
// Shared definitions for the Truxton II program-ROM line cache.
//   AW     : word-address width of the 68K program ROM (512K words)
//   LINE_W : log2 words per cache line
//   IDX_W  : log2 number of cache lines
//   TAG_W  : remaining upper address bits stored per line
//   state_t: cache controller states
package truxton2_pkg;

  localparam int unsigned AW     = 19;
  localparam int unsigned LINE_W = 2;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned TAG_W  = AW - IDX_W - LINE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    HOLD,
    FLUSHING
  } state_t;

endpackage

// File: rtl/truxton2_prg_cache_if.sv
// ROM-style read port: request (cs/addr) from the master, ok/data back from
// the slave. Used both between CPU and cache and between cache and SDRAM.
//   cs   : read request, held until ok
//   addr : word address, stable while cs
//   ok   : data valid for the current addr
//   data : 16-bit read data
interface truxton2_prg_cache_if;
  import truxton2_pkg::*;

  logic          cs;
  logic [AW-1:0] addr;
  logic          ok;
  logic [15:0]   data;

  modport master (output cs, addr, input  ok, data);
  modport slave  (input  cs, addr, output ok, data);

endinterface

// File: rtl/truxton2_dpram.sv
// Generic synchronous dual-port RAM: one write port, one registered read port.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (registered)
//   rdata : read data, valid the cycle after raddr is presented
module truxton2_dpram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write-first on an address collision: the cache re-reads the line in the
  // same cycle the last fill word and the tag are written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/truxton2_prg_cache.sv
// Read-only direct-mapped line cache between the 68K program-ROM port and
// the SDRAM bank-0 ROM channel. Misses fill a whole line, offset 0 first.
//   CLK   : 48 MHz system clock
//   RESET : asynchronous, active-high reset
//   FLUSH : level, invalidates all lines (held while downloading)
//   cpu   : slave ROM port towards the CPU
//   rom   : master ROM port towards SDRAM
//   BUSY  : high while filling a line or flushing
module truxton2_prg_cache
  import truxton2_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  truxton2_prg_cache_if.slave         cpu,
  truxton2_prg_cache_if.master        rom,
  output logic                        BUSY
);

  state_t                  state;
  logic [AW-1:0]           addr_q;
  logic [LINE_W-1:0]       cnt;
  logic                    guard;
  logic                    flush_pend;
  logic [2**IDX_W-1:0]     valid;
  logic                    cpu_ok;
  logic [15:0]             cpu_data;
  logic                    rom_cs;
  logic [AW-1:0]           rom_addr;
  logic                    busy;

  logic [TAG_W-1:0]        tag_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W+LINE_W-1:0] rd_word;
  logic [TAG_W-1:0]        tag_rd;
  logic [15:0]             data_rd;
  logic                    data_we;
  logic                    tag_we;
  logic                    hit;

  assign tag_q = addr_q[AW-1:IDX_W+LINE_W];
  assign idx_q = addr_q[IDX_W+LINE_W-1:LINE_W];

  // In IDLE the RAMs are addressed straight from the CPU so LOOKUP already
  // has the stored word and tag; elsewhere the latched address is used.
  assign rd_word = (state == IDLE) ? cpu.addr[IDX_W+LINE_W-1:0]
                                   : addr_q[IDX_W+LINE_W-1:0];

  assign data_we = (state == FILL) && !guard && rom.ok;
  assign tag_we  = data_we && (&cnt);
  assign hit     = valid[idx_q] && (tag_rd == tag_q);

  truxton2_dpram #(.ADDR_W(IDX_W + LINE_W), .DATA_W(16)) u_data (
    .clk   (CLK),
    .we    (data_we),
    .waddr ({idx_q, cnt}),
    .wdata (rom.data),
    .raddr (rd_word),
    .rdata (data_rd)
  );

  truxton2_dpram #(.ADDR_W(IDX_W), .DATA_W(TAG_W)) u_tag (
    .clk   (CLK),
    .we    (tag_we),
    .waddr (idx_q),
    .wdata (tag_q),
    .raddr (rd_word[IDX_W+LINE_W-1:LINE_W]),
    .rdata (tag_rd)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      guard      <= 1'b0;
      flush_pend <= 1'b0;
      valid      <= '0;
      cpu_ok     <= 1'b0;
      cpu_data   <= '0;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (FLUSH) begin
            valid <= '0;
            busy  <= 1'b1;
            state <= FLUSHING;
          end else if (cpu.cs && !cpu_ok) begin
            addr_q <= cpu.addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (FLUSH) begin
            valid <= '0;
            busy  <= 1'b1;
            state <= FLUSHING;
          end else if (!cpu.cs || (cpu.addr != addr_q)) begin
            // Request withdrawn (e.g. CS dropped during the fill): no OK.
            state <= IDLE;
          end else if (hit) begin
            cpu_ok   <= 1'b1;
            cpu_data <= data_rd;
            state    <= HOLD;
          end else begin
            rom_cs   <= 1'b1;
            rom_addr <= {tag_q, idx_q, {LINE_W{1'b0}}};
            cnt      <= '0;
            guard    <= 1'b1;
            busy     <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (FLUSH) flush_pend <= 1'b1;
          if (guard) begin
            // ROM_OK in the cycle after an address change belongs to the
            // previous word.
            guard <= 1'b0;
          end else if (rom.ok) begin
            if (&cnt) begin
              rom_cs <= 1'b0;
              if (flush_pend || FLUSH) begin
                flush_pend <= 1'b0;
                valid      <= '0;
                state      <= FLUSHING;
              end else begin
                valid[idx_q] <= 1'b1;
                busy         <= 1'b0;
                state        <= LOOKUP;
              end
            end else begin
              cnt      <= cnt + LINE_W'(1);
              rom_addr <= {tag_q, idx_q, cnt + LINE_W'(1)};
              guard    <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (FLUSH) begin
            cpu_ok <= 1'b0;
            valid  <= '0;
            busy   <= 1'b1;
            state  <= FLUSHING;
          end else if (!cpu.cs || (cpu.addr != addr_q)) begin
            cpu_ok <= 1'b0;
            state  <= IDLE;
          end
        end
        FLUSHING: begin
          valid <= '0;
          if (!FLUSH) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.ok   = cpu_ok;
  assign cpu.data = cpu_data;
  assign rom.cs   = rom_cs;
  assign rom.addr = rom_addr;
  assign BUSY     = busy;

endmodule
